// File: rtl/eq4.sv
// Registered 4-bit equality comparator: per-bit XNOR cells reduced by AND, with a
// per-bit mismatch vector and a saturating count of matching pairs.
module eq4 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic             res,
    output logic [3:0]       diff,
    output logic             out_valid,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [3:0] eq_bit;
    logic       eq_all;

    for (genvar i = 0; i < 4; i++) begin : g_cell
        assign eq_bit[i] = ~(a[i] ^ b[i]);
    end

    assign eq_all = &eq_bit;

    logic             res_d;
    logic [3:0]       diff_d;
    logic             out_valid_d;
    logic [CNT_W-1:0] match_cnt_d;

    always_comb begin
        res_d       = res;
        diff_d      = diff;
        out_valid_d = in_valid;
        match_cnt_d = match_cnt;
        if (in_valid) begin
            res_d  = eq_all;
            diff_d = ~eq_bit;
        end
        // Clear wins over a same-cycle increment; the count never wraps.
        if (clr_cnt) begin
            match_cnt_d = '0;
        end else if (in_valid && eq_all && (match_cnt != CntMax)) begin
            match_cnt_d = match_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res       <= 1'b0;
            diff      <= 4'b0000;
            out_valid <= 1'b0;
            match_cnt <= '0;
        end else begin
            res       <= res_d;
            diff      <= diff_d;
            out_valid <= out_valid_d;
            match_cnt <= match_cnt_d;
        end
    end

endmodule

// File: tb/tb_eq4.sv
// Directed bench for eq4: default-width instance for the main function and sweep,
// plus a CNT_W=2 instance for counter saturation.
module tb_eq4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b, a2, b2;
    logic       in_valid, clr_cnt, in_valid2, clr_cnt2;
    logic       res, out_valid, res2, out_valid2;
    logic [3:0] diff, diff2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    eq4 #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .res(res), .diff(diff), .out_valid(out_valid), .match_cnt(match_cnt)
    );

    eq4 #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a2), .b(b2), .in_valid(in_valid2), .clr_cnt(clr_cnt2),
        .res(res2), .diff(diff2), .out_valid(out_valid2), .match_cnt(match_cnt2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present current inputs at the next rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic r, input logic [3:0] d,
                              input logic ov, input logic [7:0] c);
        check({tag, ".res"}, {15'd0, res}, {15'd0, r});
        check({tag, ".diff"}, {12'd0, diff}, {12'd0, d});
        check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, ov});
        check({tag, ".match_cnt"}, {8'd0, match_cnt}, {8'd0, c});
    endtask

    initial begin
        rst = 1'b1; a = 4'h0; b = 4'h0; in_valid = 1'b0; clr_cnt = 1'b0;
        a2 = 4'h0; b2 = 4'h0; in_valid2 = 1'b0; clr_cnt2 = 1'b0;
        step();
        step();
        check_main("reset", 1'b0, 4'b0000, 1'b0, 8'd0);
        check("reset.sat_cnt", {14'd0, match_cnt2}, 16'd0);
        check("reset.sat_out_valid", {15'd0, out_valid2}, 16'd0);

        rst = 1'b0;
        in_valid = 1'b1; a = 4'b1111; b = 4'b1111;
        step();
        check_main("ff_ff", 1'b1, 4'b0000, 1'b1, 8'd1);

        a = 4'b1000; b = 4'b1010;
        step();
        check_main("8_a", 1'b0, 4'b0010, 1'b1, 8'd1);

        a = 4'b0011; b = 4'b0011;
        step();
        check_main("3_3", 1'b1, 4'b0000, 1'b1, 8'd2);

        a = 4'b1001; b = 4'b1001;
        step();
        check_main("9_9", 1'b1, 4'b0000, 1'b1, 8'd3);

        a = 4'b0101; b = 4'b0110;
        step();
        check_main("5_6", 1'b0, 4'b0011, 1'b1, 8'd3);

        // Idle: result registers hold; inputs change to show they are ignored.
        in_valid = 1'b0; a = 4'b1111; b = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check_main("idle", 1'b0, 4'b0011, 1'b0, 8'd3);
        end

        clr_cnt = 1'b1;
        step();
        check_main("clr_idle", 1'b0, 4'b0011, 1'b0, 8'd0);

        a = 4'b0111; b = 4'b0111; in_valid = 1'b1;
        step();
        check_main("clr_with_match", 1'b1, 4'b0000, 1'b1, 8'd0);
        clr_cnt = 1'b0;
        in_valid = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a = 4'(i); b = 4'(j);
                step();
                check("sweep.res", {15'd0, res}, {15'd0, (i == j)});
                check("sweep.diff", {12'd0, diff}, {12'd0, 4'(i) ^ 4'(j)});
                check("sweep.out_valid", {15'd0, out_valid}, 16'd1);
            end
        end
        in_valid = 1'b0;
        check("sweep.match_cnt", {8'd0, match_cnt}, 16'd16);

        in_valid2 = 1'b1; a2 = 4'b1010; b2 = 4'b1010;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("sat.match_cnt", {14'd0, match_cnt2}, (i < 3) ? 16'(i) : 16'd3);
            check("sat.res", {15'd0, res2}, 16'd1);
        end
        clr_cnt2 = 1'b1;
        step();
        check("sat.clr_cnt", {14'd0, match_cnt2}, 16'd0);
        check("sat.clr_res", {15'd0, res2}, 16'd1);
        check("sat.clr_out_valid", {15'd0, out_valid2}, 16'd1);
        clr_cnt2 = 1'b0; in_valid2 = 1'b0;

        in_valid = 1'b1; a = 4'b1100; b = 4'b1100;
        step();
        check_main("pre_rst", 1'b1, 4'b0000, 1'b1, 8'd17);

        rst = 1'b1; a = 4'b0101; b = 4'b0101;
        step();
        check_main("rst_with_valid", 1'b0, 4'b0000, 1'b0, 8'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check_main("post_rst", 1'b0, 4'b0000, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
